dmem_req_ctrl: RTL and testbench
================================

DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 Parameter: RDATA_RST, 32'h0, value loaded into ec_data_rdata on reset.
REQ-002 clk  in  1  clock; all state changes on posedge clk.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 mem_valid  in  1  MEM stage holds a load/store this cycle.
REQ-005 mem_wr  in  1  1 = store, 0 = load.
REQ-006 mem_size  in  2  0 byte, 1 half, 2 word; 3 is illegal and is treated as word.
REQ-007 mem_addr  in  32  byte address.
REQ-008 mem_wdata  in  32  store data, already lane-aligned.
REQ-009 mem_load_sign  in  1  1 = sign-extend the load (only used under LOAD_EXT_EN).
REQ-010 refresh  in  1  pipeline flush (exception/eret).
REQ-011 pipe_stall  in  1  downstream stall holding the MEM stage.
REQ-012 data_req / data_wr / data_size / data_addr / data_wdata  out  1/1/2/32/32  sram-like request channel.
REQ-013 data_addr_ok  in  1  request accepted.
REQ-014 data_data_ok  in  1  response/write completion.
REQ-015 data_rdata  in  32  response data.
REQ-016 mem_stall  out  1  freezes the pipeline while the access is incomplete.
REQ-017 ec_data_rdata  out  32  captured load data, fed to the EC/WB segment.
REQ-018 ec_data_valid  out  1  ec_data_rdata holds data from the current instruction.

Function
REQ-019 States: IDLE, REQ, WAIT, DONE, DRAIN; one access per instruction.
REQ-020 IDLE: data_req = mem_valid & ~refresh (combinational); the request fields pass mem_* through.
- addr_ok in the same cycle -> WAIT.
- Otherwise, if mem_valid & ~refresh -> REQ and the fields are registered.
REQ-021 REQ: data_req=1 with registered fields held stable.
- addr_ok -> WAIT.
- refresh & ~addr_ok -> IDLE, with data_req=0 from the next cycle.
- refresh & addr_ok -> DRAIN.
REQ-022 WAIT: data_req=0.
- data_ok -> DONE; a load captures data_rdata into ec_data_rdata and sets ec_data_valid=1.
- refresh & ~data_ok -> DRAIN.
- refresh & data_ok -> IDLE, response discarded.
REQ-023 Stores never update ec_data_rdata; data_ok completes the store; ec_data_valid=0.
REQ-024 DONE: no request is issued.
- ~pipe_stall or refresh -> IDLE.
- ec_data_valid clears on leaving DONE.
REQ-025 DRAIN: data_req=0.
- data_ok -> IDLE, data discarded, ec_data_valid stays 0.
- No new request is issued until DRAIN exits.
REQ-026 mem_stall = (IDLE & mem_valid & ~refresh) | REQ | WAIT | (DRAIN & mem_valid).
- mem_stall=0 in DONE.
- Minimum load latency: addr_ok in cycle 0, data_ok in cycle 1, data valid in cycle 2.
REQ-027 data_ok is never taken in the addr_ok cycle; data_ok in IDLE/REQ/DONE is ignored.

Reset
REQ-028 With resetn=0 at posedge: state=IDLE, ec_data_rdata=RDATA_RST, ec_data_valid=0, registered request fields 0.
REQ-029 While resetn=0: data_req=0 and mem_stall=0.
REQ-030 Reset mid-transaction aborts without draining.

Configuration
REQ-031 Macro LOAD_EXT_EN defined:
- Captured load data is shifted by mem_addr[1:0].
- It is then zero/sign-extended per mem_size and mem_load_sign.
REQ-032 Macro LOAD_EXT_EN undefined:
- data_rdata is captured raw.
- mem_load_sign is unused.
- Alignment is done downstream.

Structure
REQ-033 Package cpu_mem_pkg holds the state encoding and the SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
REQ-034 Sub-module load_ext (combinational shift/extend) is instantiated only under LOAD_EXT_EN.

Verification
REQ-035 Load word at 0x100, addr_ok in cycle 0, data_ok in cycle 1 with 0xDEADBEEF -> ec_data_rdata=0xDEADBEEF and ec_data_valid=1 in cycle 2; mem_stall=0 in cycle 2.
REQ-036 addr_ok withheld 3 cycles -> data_req high 4 cycles with data_addr constant; mem_stall high throughout.
REQ-037 Refresh in WAIT, then data_ok 2 cycles later, then a new load -> no capture from the old load; the new data_req waits until after that data_ok.
REQ-038 Store of 0x12345678, data_ok -> ec_data_rdata unchanged and ec_data_valid=0.
REQ-039 LOAD_EXT_EN, lb at addr[1:0]=3 with rdata 0x80FFFFFF, sign=1 -> 0xFFFFFF80; same with sign=0 -> 0x00000080.
REQ-040 resetn=0 in WAIT -> next cycle state IDLE, mem_stall=0, ec_data_rdata=RDATA_RST.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared data-memory request definitions: state encoding, access sizes, request payload.
// Exports: state_e, SIZE_BYTE/SIZE_HALF/SIZE_WORD, mem_req_t, norm_size().
package cpu_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // The illegal size encoding is handled as a full word.
  function automatic logic [SIZE_W-1:0] norm_size(input logic [SIZE_W-1:0] s);
    return (s == 2'd3) ? SIZE_WORD : s;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load alignment: shift response by byte offset, then zero/sign-extend.
// Only built when LOAD_EXT_EN is defined.
// Ports: rdata (raw response), offset (addr[1:0]), size, sign -> data (aligned, extended).
`ifdef LOAD_EXT_EN
module load_ext
  import cpu_mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [SIZE_W-1:0] size,
  input  logic              sign,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;
  logic              ext;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    ext     = 1'b0;
    data    = shifted;
    case (size)
      SIZE_BYTE: begin
        ext  = sign & shifted[7];
        data = {{24{ext}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        ext  = sign & shifted[15];
        data = {{16{ext}}, shifted[15:0]};
      end
      default: data = shifted;
    endcase
  end

endmodule
`endif

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller between the MEM stage and an sram-like bus.
// One access per instruction; stalls the pipe until done; drains orphaned
// responses after a flush. Optional macro LOAD_EXT_EN adds load alignment and
// sign/zero extension (load_ext); otherwise data_rdata is captured raw.
// Ports: clk, resetn (sync, active-low); mem_* from MEM stage, refresh, pipe_stall;
//        data_* request/response channel; mem_stall; ec_data_rdata/ec_data_valid.
module dmem_req_ctrl
  import cpu_mem_pkg::*;
#(
  parameter logic [DATA_W-1:0] RDATA_RST = 32'h0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_wr,
  input  logic [SIZE_W-1:0] mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_load_sign,
  input  logic              refresh,
  input  logic              pipe_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [SIZE_W-1:0] data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] ec_data_rdata,
  output logic              ec_data_valid
);

  state_e            state;
  state_e            state_next;
  mem_req_t          req_q;
  logic [DATA_W-1:0] rdata_cap;
  logic              accept;

  assign accept = mem_valid & ~refresh;

`ifdef LOAD_EXT_EN
  logic req_sign;

  load_ext u_load_ext (
    .rdata  (data_rdata),
    .offset (req_q.addr[1:0]),
    .size   (req_q.size),
    .sign   (req_sign),
    .data   (rdata_cap)
  );
`else
  logic unused_sign;
  assign unused_sign = mem_load_sign;
  assign rdata_cap   = data_rdata;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = data_addr_ok ? ST_WAIT : ST_REQ;
      end
      ST_REQ: begin
        if (data_addr_ok) state_next = refresh ? ST_DRAIN : ST_WAIT;
        else if (refresh) state_next = ST_IDLE;
      end
      ST_WAIT: begin
        // A flush that coincides with the response just drops it.
        if (data_data_ok) state_next = refresh ? ST_IDLE : ST_DONE;
        else if (refresh) state_next = ST_DRAIN;
      end
      ST_DONE: begin
        if (!pipe_stall || refresh) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (data_data_ok) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: IDLE forwards the MEM-stage request so addr_ok can land in cycle 0
  always_comb begin
    data_req   = 1'b0;
    data_wr    = req_q.wr;
    data_size  = req_q.size;
    data_addr  = req_q.addr;
    data_wdata = req_q.wdata;
    mem_stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        data_req   = accept;
        data_wr    = mem_wr;
        data_size  = norm_size(mem_size);
        data_addr  = mem_addr;
        data_wdata = mem_wdata;
        mem_stall  = accept;
      end
      ST_REQ: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
      end
      ST_WAIT:  mem_stall = 1'b1;
      ST_DRAIN: mem_stall = mem_valid;
      default: ;
    endcase
    if (!resetn) begin
      data_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  // Request capture and load-data writeback
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_q         <= '0;
      ec_data_rdata <= RDATA_RST;
      ec_data_valid <= 1'b0;
`ifdef LOAD_EXT_EN
      req_sign      <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE && accept) begin
        req_q <= {mem_wr, norm_size(mem_size), mem_addr, mem_wdata};
`ifdef LOAD_EXT_EN
        req_sign <= mem_load_sign;
`endif
      end
      if (state == ST_WAIT && data_data_ok && !refresh) begin
        ec_data_valid <= ~req_q.wr;
        if (!req_q.wr) ec_data_rdata <= rdata_cap;
      end else if (state == ST_DONE && state_next != ST_DONE) begin
        ec_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed self-checking bench for dmem_req_ctrl (default build or LOAD_EXT_EN).
module tb_dmem_req_ctrl;
  import cpu_mem_pkg::*;

  localparam logic [31:0] RST_VAL = 32'hA5A5_0001;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_load_sign;
  logic        refresh;
  logic        pipe_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_stall;
  logic [31:0] ec_data_rdata;
  logic        ec_data_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rd;
  logic [31:0] exp_rd;

  dmem_req_ctrl #(.RDATA_RST(RST_VAL)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_valid     (mem_valid),
    .mem_wr        (mem_wr),
    .mem_size      (mem_size),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_load_sign (mem_load_sign),
    .refresh       (refresh),
    .pipe_stall    (pipe_stall),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .mem_stall     (mem_stall),
    .ec_data_rdata (ec_data_rdata),
    .ec_data_valid (ec_data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid     = 1'b0;
    mem_wr        = 1'b0;
    mem_size      = SIZE_WORD;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_load_sign = 1'b0;
    refresh       = 1'b0;
    pipe_stall    = 1'b0;
    data_addr_ok  = 1'b0;
    data_data_ok  = 1'b0;
    data_rdata    = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn    = 1'b0;
    mem_valid = 1'b1;
    #1;
    n_tests++;
    if ({data_req, mem_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_gating: req/stall=%b want 00", {data_req, mem_stall});
    end
    cycle();
    cycle();
    n_tests++;
    if ({ec_data_valid, ec_data_rdata} !== {1'b0, RST_VAL}) begin
      n_fail++;
      $display("FAIL reset_regs: valid=%b rdata=%h want 0 %h", ec_data_valid, ec_data_rdata, RST_VAL);
    end
    idle_inputs();
    resetn = 1'b1;
    cycle();
  endtask

  task automatic test_load_min();
    mem_valid = 1'b1; mem_wr = 1'b0; mem_size = SIZE_WORD; mem_addr = 32'h100;
    data_addr_ok = 1'b1;
    #1;
    n_tests++;
    if ({data_req, data_wr, data_addr, mem_stall} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
      n_fail++;
      $display("FAIL load_min_c0: req=%b wr=%b addr=%h stall=%b want 1 0 00000100 1",
               data_req, data_wr, data_addr, mem_stall);
    end
    cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    #1;
    n_tests++;
    if ({data_req, mem_stall} !== 2'b01) begin
      n_fail++;
      $display("FAIL load_min_c1: req/stall=%b want 01", {data_req, mem_stall});
    end
    cycle();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    n_tests++;
    if ({ec_data_valid, ec_data_rdata, mem_stall} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL load_min_c2: valid=%b rdata=%h stall=%b want 1 deadbeef 0",
               ec_data_valid, ec_data_rdata, mem_stall);
    end
    cycle();
    mem_valid = 1'b0;
    #1;
    n_tests++;
    if ({ec_data_valid, data_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_min_c3: valid/req=%b want 00", {ec_data_valid, data_req});
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_addr_ok_delay();
    mem_valid = 1'b1; mem_wr = 1'b0; mem_size = SIZE_HALF; mem_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      if (i > 0) mem_addr = 32'hFFFF_0000 + 32'(i);
      #1;
      n_tests++;
      if ({data_req, data_addr, data_size, mem_stall} !== {1'b1, 32'h200, SIZE_HALF, 1'b1}) begin
        n_fail++;
        $display("FAIL addr_ok_delay_c%0d: req=%b addr=%h size=%0d stall=%b want 1 00000200 1 1",
                 i, data_req, data_addr, data_size, mem_stall);
      end
      cycle();
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h11223344; pipe_stall = 1'b1;
    cycle();
    data_data_ok = 1'b0;
`ifdef LOAD_EXT_EN
    exp_rd = 32'h0000_3344;
`else
    exp_rd = 32'h1122_3344;
`endif
    #1;
    n_tests++;
    if ({ec_data_valid, ec_data_rdata, mem_stall} !== {1'b1, exp_rd, 1'b0}) begin
      n_fail++;
      $display("FAIL addr_ok_delay_done: valid=%b rdata=%h stall=%b want 1 %h 0",
               ec_data_valid, ec_data_rdata, mem_stall, exp_rd);
    end
    cycle();
    n_tests++;
    if (ec_data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold_stall: valid=%b want 1", ec_data_valid);
    end
    pipe_stall = 1'b0;
    mem_valid  = 1'b0;
    cycle();
    n_tests++;
    if (ec_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_exit_clear: valid=%b want 0", ec_data_valid);
    end
    last_rd = exp_rd;
    idle_inputs();
  endtask

  task automatic test_refresh_drain();
    mem_valid = 1'b1; mem_addr = 32'h300; data_addr_ok = 1'b1;
    cycle();
    data_addr_ok = 1'b0; refresh = 1'b1; mem_valid = 1'b0;
    #1;
    n_tests++;
    if ({data_req, mem_stall} !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_wait_flush: req/stall=%b want 01", {data_req, mem_stall});
    end
    cycle();
    refresh = 1'b0; mem_valid = 1'b1; mem_addr = 32'h400;
    #1;
    n_tests++;
    if ({data_req, mem_stall} !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_blocks_req: req/stall=%b want 01", {data_req, mem_stall});
    end
    cycle();
    data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
    #1;
    n_tests++;
    if (data_req !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_exit_req: req=%b want 0", data_req);
    end
    cycle();
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    #1;
    n_tests++;
    if ({data_req, data_addr, ec_data_valid, ec_data_rdata} !== {1'b1, 32'h400, 1'b0, last_rd}) begin
      n_fail++;
      $display("FAIL drain_new_load: req=%b addr=%h valid=%b rdata=%h want 1 00000400 0 %h",
               data_req, data_addr, ec_data_valid, ec_data_rdata, last_rd);
    end
    cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    cycle();
    data_data_ok = 1'b0;
    #1;
    n_tests++;
    if ({ec_data_valid, ec_data_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL drain_new_capture: valid=%b rdata=%h want 1 cafef00d", ec_data_valid, ec_data_rdata);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_store();
    mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h12345678;
    data_addr_ok = 1'b1;
    #1;
    n_tests++;
    if ({data_req, data_wr, data_wdata} !== {1'b1, 1'b1, 32'h12345678}) begin
      n_fail++;
      $display("FAIL store_req: req=%b wr=%b wdata=%h want 1 1 12345678", data_req, data_wr, data_wdata);
    end
    cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFFFFFF;
    cycle();
    data_data_ok = 1'b0;
    #1;
    n_tests++;
    if ({ec_data_valid, ec_data_rdata, mem_stall} !== {1'b0, 32'hCAFEF00D, 1'b0}) begin
      n_fail++;
      $display("FAIL store_done: valid=%b rdata=%h stall=%b want 0 cafef00d 0",
               ec_data_valid, ec_data_rdata, mem_stall);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_refresh_cases();
    mem_valid = 1'b1; mem_addr = 32'h600;
    cycle();
    refresh = 1'b1;
    #1;
    n_tests++;
    if ({data_req, data_addr} !== {1'b1, 32'h600}) begin
      n_fail++;
      $display("FAIL req_hold_on_flush: req=%b addr=%h want 1 00000600", data_req, data_addr);
    end
    cycle();
    refresh = 1'b0; mem_valid = 1'b0;
    #1;
    n_tests++;
    if ({data_req, mem_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL req_flush_idle: req/stall=%b want 00", {data_req, mem_stall});
    end
    cycle();
    mem_valid = 1'b1; mem_addr = 32'h700; data_addr_ok = 1'b1;
    cycle();
    data_addr_ok = 1'b0; refresh = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BADF00D;
    mem_valid = 1'b0;
    cycle();
    refresh = 1'b0; data_data_ok = 1'b0;
    #1;
    n_tests++;
    if ({data_req, mem_stall, ec_data_valid, ec_data_rdata} !== {3'b000, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL wait_flush_with_ok: req=%b stall=%b valid=%b rdata=%h want 0 0 0 cafef00d",
               data_req, mem_stall, ec_data_valid, ec_data_rdata);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_size3();
    mem_valid = 1'b1; mem_size = 2'd3; mem_addr = 32'h800; data_addr_ok = 1'b1;
    #1;
    n_tests++;
    if (data_size !== SIZE_WORD) begin
      n_fail++;
      $display("FAIL size3_as_word: size=%0d want 2", data_size);
    end
    cycle();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h87654321;
    cycle();
    data_data_ok = 1'b0;
    #1;
    n_tests++;
    if ({ec_data_valid, ec_data_rdata} !== {1'b1, 32'h87654321}) begin
      n_fail++;
      $display("FAIL size3_capture: valid=%b rdata=%h want 1 87654321", ec_data_valid, ec_data_rdata);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_load_ext();
    for (int s = 1; s >= 0; s--) begin
      mem_valid = 1'b1; mem_size = SIZE_BYTE; mem_addr = 32'h903;
      mem_load_sign = 1'(s); data_addr_ok = 1'b1;
      cycle();
      mem_load_sign = 1'(1 - s);
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h80FFFFFF;
      cycle();
      data_data_ok = 1'b0;
`ifdef LOAD_EXT_EN
      exp_rd = (s == 1) ? 32'hFFFFFF80 : 32'h00000080;
`else
      exp_rd = 32'h80FFFFFF;
`endif
      #1;
      n_tests++;
      if ({ec_data_valid, ec_data_rdata} !== {1'b1, exp_rd}) begin
        n_fail++;
        $display("FAIL load_ext_sign%0d: valid=%b rdata=%h want 1 %h", s, ec_data_valid, ec_data_rdata, exp_rd);
      end
      idle_inputs();
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_addr = 32'hA00; data_addr_ok = 1'b1;
    cycle();
    data_addr_ok = 1'b0; resetn = 1'b0;
    #1;
    n_tests++;
    if ({data_req, mem_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_gating: req/stall=%b want 00", {data_req, mem_stall});
    end
    cycle();
    resetn = 1'b1; mem_valid = 1'b0;
    #1;
    n_tests++;
    if ({mem_stall, ec_data_valid, ec_data_rdata} !== {2'b00, RST_VAL}) begin
      n_fail++;
      $display("FAIL reset_mid_state: stall=%b valid=%b rdata=%h want 0 0 %h",
               mem_stall, ec_data_valid, ec_data_rdata, RST_VAL);
    end
    data_data_ok = 1'b1; data_rdata = 32'h5555AAAA;
    cycle();
    data_data_ok = 1'b0;
    mem_valid = 1'b1; mem_addr = 32'hB00;
    #1;
    n_tests++;
    if ({data_req, data_addr, ec_data_rdata, ec_data_valid} !== {1'b1, 32'hB00, RST_VAL, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_idle: req=%b addr=%h rdata=%h valid=%b want 1 00000b00 %h 0",
               data_req, data_addr, ec_data_rdata, ec_data_valid, RST_VAL);
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    last_rd = 32'h0;
    exp_rd  = 32'h0;
    test_reset();
    test_load_min();
    test_addr_ok_delay();
    test_refresh_drain();
    test_store();
    test_refresh_cases();
    test_size3();
    test_load_ext();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
